lvds_pixel_packer: RTL and testbench

//   Downstream of the A1100 LVDS receiver: takes deserialized pixel samples (DW bits + D_GROUP flag),

---
 rtl/lvds_pixel_packer.sv | 223 ++++++++++++++++++++++
 tb/tb_lvds_pixel_packer.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lvds_pixel_packer.sv
// Frame-aligns deserialized LVDS pixel samples, packs four 16-bit lanes per 64-bit word and streams
// them out over AXI4-Stream through a FIFO. Define LVDS_PACK_HDR_EN to prepend a per-frame header word.
module lvds_pixel_packer #(
  parameter int DW         = 15,
  parameter int FIFO_DEPTH = 512
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enable,
  input  logic [DW-1:0] pix_data,
  input  logic          pix_valid,
  input  logic          pix_group,
  input  logic          frame_start,
  input  logic          line_end,
  output logic [63:0]   m_tdata,
  output logic [7:0]    m_tkeep,
  output logic          m_tlast,
  output logic          m_tuser,
  output logic          m_tvalid,
  input  logic          m_tready,
  output logic          overflow,
  output logic [15:0]   drop_cnt
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = 74;
  localparam logic [AW:0] DEPTH = (AW+1)'(FIFO_DEPTH);

  typedef enum logic {ST_WAIT_SOF, ST_PACK} state_t;

  state_t        state, state_nxt;
  logic [1:0]    lane_cnt, lane_cnt_nxt, lane_idx;
  logic [15:0]   lane_buf [0:2];
  logic [15:0]   lane_in;
  logic          lane_we;
  logic          push_req, push_ok, drop, sof_take;
  logic [63:0]   push_data, pix_word;
  logic [7:0]    push_keep, pix_keep;
  logic          push_last, push_user;

  logic [EW-1:0] mem [0:FIFO_DEPTH-1];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   mem_count, total;
  logic          out_valid, pop, load, space_ok;
  logic [EW-1:0] out_word;

`ifdef LVDS_PACK_HDR_EN
  logic [15:0]   frame_cnt, line_cnt;
  logic [AW:0]   free_slots;
  logic          hdr_room, line_inc;
`else
  logic          first_pending;
`endif

  always_comb begin
    lane_in = '0;
    lane_in[DW-1:0] = pix_data;
    lane_in[15] = pix_group;
  end

  // Total occupancy includes the output register so the usable capacity is exactly FIFO_DEPTH.
  assign pop      = out_valid & m_tready;
  assign load     = (mem_count != '0) & (~out_valid | pop);
  assign total    = mem_count + {{AW{1'b0}}, out_valid};
  assign space_ok = (total != DEPTH) | pop;
  assign push_ok  = push_req & space_ok;

`ifdef LVDS_PACK_HDR_EN
  assign free_slots = DEPTH - total + {{AW{1'b0}}, pop};
  assign hdr_room   = free_slots >= (AW+1)'(2);
`endif

  always_comb begin
    pix_word = '0;
    pix_keep = '0;
    for (int k = 0; k < 3; k++) begin
      if (k < int'(lane_cnt)) begin
        pix_word[16*k +: 16] = lane_buf[k];
        pix_keep[2*k +: 2]   = 2'b11;
      end
    end
    pix_word[{lane_cnt, 4'b0000} +: 16] = lane_in;
    pix_keep[{lane_cnt, 1'b0} +: 2]     = 2'b11;
  end

  always_comb begin
    state_nxt    = state;
    lane_cnt_nxt = lane_cnt;
    lane_we      = 1'b0;
    lane_idx     = lane_cnt;
    push_req     = 1'b0;
    push_data    = pix_word;
    push_keep    = pix_keep;
    push_last    = line_end;
    push_user    = 1'b0;
    sof_take     = 1'b0;
    drop         = 1'b0;
`ifdef LVDS_PACK_HDR_EN
    line_inc     = 1'b0;
`endif
    if (state == ST_PACK && !enable) begin
      state_nxt    = ST_WAIT_SOF;
      lane_cnt_nxt = '0;
    end else if (pix_valid && frame_start && enable) begin
`ifdef LVDS_PACK_HDR_EN
      if (hdr_room) begin
        sof_take  = 1'b1;
        push_req  = 1'b1;
        push_data = {16'hA110, frame_cnt, 16'h0000, line_cnt};
        push_keep = 8'hFF;
        push_last = 1'b0;
        push_user = 1'b1;
      end else begin
        drop = 1'b1;
      end
`else
      sof_take = 1'b1;
`endif
      // Any partial word is abandoned; the frame-start sample always lands in lane 0.
      if (sof_take) begin
        state_nxt    = ST_PACK;
        lane_we      = 1'b1;
        lane_idx     = 2'd0;
        lane_cnt_nxt = 2'd1;
      end
    end else if (state == ST_PACK && pix_valid) begin
`ifdef LVDS_PACK_HDR_EN
      line_inc = line_end;
`endif
      if (lane_cnt == 2'd3 || line_end) begin
        push_req     = 1'b1;
`ifdef LVDS_PACK_HDR_EN
        push_user    = 1'b0;
`else
        push_user    = first_pending;
`endif
        lane_cnt_nxt = '0;
      end else begin
        lane_we      = 1'b1;
        lane_cnt_nxt = lane_cnt + 2'd1;
      end
    end
    if (push_req && !space_ok) drop = 1'b1;
    if (drop) begin
      state_nxt    = ST_WAIT_SOF;
      lane_cnt_nxt = '0;
      lane_we      = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_WAIT_SOF;
      lane_cnt <= '0;
      overflow <= 1'b0;
      drop_cnt <= '0;
      for (int k = 0; k < 3; k++) lane_buf[k] <= '0;
    end else begin
      state    <= state_nxt;
      lane_cnt <= lane_cnt_nxt;
      for (int k = 0; k < 3; k++) begin
        if (lane_we && lane_idx == 2'(k)) lane_buf[k] <= lane_in;
      end
      if (drop) begin
        overflow <= 1'b1;
        if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
      end
    end
  end

`ifdef LVDS_PACK_HDR_EN
  // The header reports the line count of the frame that is just ending.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt <= '0;
      line_cnt  <= '0;
    end else if (sof_take) begin
      frame_cnt <= frame_cnt + 16'd1;
      line_cnt  <= '0;
    end else if (line_inc) begin
      line_cnt  <= line_cnt + 16'd1;
    end
  end
`else
  always_ff @(posedge clk or posedge rst) begin
    if (rst) first_pending <= 1'b0;
    else if (sof_take) first_pending <= 1'b1;
    else if (push_req) first_pending <= 1'b0;
  end
`endif

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= {push_user, push_last, push_keep, push_data};
  end

  // Output register refills from the memory on the cycle it is popped, giving one word per cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      mem_count <= '0;
      out_valid <= 1'b0;
      out_word  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (load) begin
        rd_ptr   <= rd_ptr + AW'(1);
        out_word <= mem[rd_ptr];
      end
      if (load) out_valid <= 1'b1;
      else if (pop) out_valid <= 1'b0;
      case ({push_ok, load})
        2'b10:   mem_count <= mem_count + (AW+1)'(1);
        2'b01:   mem_count <= mem_count - (AW+1)'(1);
        default: ;
      endcase
    end
  end

  assign {m_tuser, m_tlast, m_tkeep, m_tdata} = out_word;
  assign m_tvalid = out_valid;

endmodule

// File: tb/tb_lvds_pixel_packer.sv
// Directed bench for lvds_pixel_packer (DW=15, FIFO_DEPTH=16); expectations follow LVDS_PACK_HDR_EN
// when it is defined so the same sequence covers both builds.
module tb_lvds_pixel_packer;
  localparam int DW = 15;
  localparam int FIFO_DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          enable, pix_valid, pix_group, frame_start, line_end, m_tready;
  logic [DW-1:0] pix_data;
  logic [63:0]   m_tdata;
  logic [7:0]    m_tkeep;
  logic          m_tlast, m_tuser, m_tvalid, overflow;
  logic [15:0]   drop_cnt;

  int checks = 0;
  int errors = 0;
  logic [73:0] got [$];

  always #5 clk = ~clk;

  lvds_pixel_packer #(.DW(DW), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .rst(rst), .enable(enable), .pix_data(pix_data), .pix_valid(pix_valid),
    .pix_group(pix_group), .frame_start(frame_start), .line_end(line_end),
    .m_tdata(m_tdata), .m_tkeep(m_tkeep), .m_tlast(m_tlast), .m_tuser(m_tuser),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .overflow(overflow), .drop_cnt(drop_cnt)
  );

  // Accepted beats are collected mid-cycle, where handshake signals are settled.
  always @(negedge clk) begin
    if (!rst && m_tvalid && m_tready) got.push_back({m_tuser, m_tlast, m_tkeep, m_tdata});
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkWord(input string tag, input logic [63:0] d, input logic [7:0] k,
                           input logic l, input logic u);
    logic [73:0] w;
    w = 'x;
    if (got.size() != 0) w = got.pop_front();
    checkOutput(tag, 80'(w), 80'({u, l, k, d}));
  endtask

  task automatic expectCount(input string tag, input int n);
    int cyc;
    cyc = 0;
    while (got.size() < n && cyc < 400) begin
      @(posedge clk); #1;
      cyc++;
    end
    repeat (4) begin @(posedge clk); #1; end
    checkOutput(tag, 80'(got.size()), 80'(n));
  endtask

  task automatic applyStimulus(input logic [DW-1:0] d, input logic g, input logic fs, input logic le);
    pix_data = d; pix_group = g; frame_start = fs; line_end = le; pix_valid = 1'b1;
    @(posedge clk); #1;
    pix_valid = 1'b0; frame_start = 1'b0; line_end = 1'b0;
  endtask

  task automatic sendLine(input int base, input int n, input logic g, input logic fs);
    for (int i = 0; i < n; i++) applyStimulus(DW'(base + i), g, fs && (i == 0), i == n - 1);
  endtask

  initial begin
    enable = 1'b1; pix_valid = 1'b0; pix_group = 1'b0; frame_start = 1'b0; line_end = 1'b0;
    pix_data = '0; m_tready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_tvalid", 80'(m_tvalid), 80'(0));
    checkOutput("rst_tdata", 80'(m_tdata), 80'(0));
    checkOutput("rst_tkeep", 80'(m_tkeep), 80'(0));
    checkOutput("rst_tlast", 80'(m_tlast), 80'(0));
    checkOutput("rst_tuser", 80'(m_tuser), 80'(0));
    checkOutput("rst_overflow", 80'(overflow), 80'(0));
    checkOutput("rst_drop_cnt", 80'(drop_cnt), 80'(0));
    rst = 1'b0;
    @(posedge clk); #1;

    // Samples ahead of any frame start produce nothing
    sendLine(16'h0101, 5, 1'b0, 1'b0);
    expectCount("pre_sof_count", 0);

    // Frame A, line 1: eight samples, two full words
    sendLine(1, 8, 1'b0, 1'b1);
`ifdef LVDS_PACK_HDR_EN
    expectCount("l1_count", 3);
    checkWord("l1_hdr", 64'hA110_0000_0000_0000, 8'hFF, 1'b0, 1'b1);
    checkWord("l1_w0", 64'h0004_0003_0002_0001, 8'hFF, 1'b0, 1'b0);
`else
    expectCount("l1_count", 2);
    checkWord("l1_w0", 64'h0004_0003_0002_0001, 8'hFF, 1'b0, 1'b1);
`endif
    checkWord("l1_w1", 64'h0008_0007_0006_0005, 8'hFF, 1'b1, 1'b0);

    // Line 2: six samples with group flag, partial last word; also checks push-to-valid latency
    applyStimulus(15'h11, 1'b1, 1'b0, 1'b0);
    applyStimulus(15'h12, 1'b1, 1'b0, 1'b0);
    applyStimulus(15'h13, 1'b1, 1'b0, 1'b0);
    applyStimulus(15'h14, 1'b1, 1'b0, 1'b0);
    checkOutput("lat_cycle1", 80'(m_tvalid), 80'(0));
    applyStimulus(15'h15, 1'b1, 1'b0, 1'b0);
    checkOutput("lat_cycle2", 80'(m_tvalid), 80'(1));
    applyStimulus(15'h16, 1'b1, 1'b0, 1'b1);
    expectCount("l2_count", 2);
    checkWord("l2_w0", 64'h8014_8013_8012_8011, 8'hFF, 1'b0, 1'b0);
    checkWord("l2_w1", 64'h0000_0000_8016_8015, 8'h0F, 1'b1, 1'b0);

    // Line 3: full word that also ends the line
    sendLine(16'h31, 4, 1'b0, 1'b0);
    expectCount("l3_count", 1);
    checkWord("l3_w0", 64'h0034_0033_0032_0031, 8'hFF, 1'b1, 1'b0);

    // Frame B: one line
    sendLine(16'h41, 4, 1'b0, 1'b1);
`ifdef LVDS_PACK_HDR_EN
    expectCount("fb_count", 2);
    checkWord("fb_hdr", 64'hA110_0001_0000_0003, 8'hFF, 1'b0, 1'b1);
    checkWord("fb_w0", 64'h0044_0043_0042_0041, 8'hFF, 1'b1, 1'b0);
`else
    expectCount("fb_count", 1);
    checkWord("fb_w0", 64'h0044_0043_0042_0041, 8'hFF, 1'b1, 1'b1);
`endif

    // Frame C: restart after two samples discards the partial word
    applyStimulus(15'h51, 1'b0, 1'b1, 1'b0);
    applyStimulus(15'h52, 1'b0, 1'b0, 1'b0);
    sendLine(16'h61, 4, 1'b0, 1'b1);
`ifdef LVDS_PACK_HDR_EN
    expectCount("fc_count", 3);
    checkWord("fc_hdr0", 64'hA110_0002_0000_0001, 8'hFF, 1'b0, 1'b1);
    checkWord("fc_hdr1", 64'hA110_0003_0000_0000, 8'hFF, 1'b0, 1'b1);
    checkWord("fc_w0", 64'h0064_0063_0062_0061, 8'hFF, 1'b1, 1'b0);
`else
    expectCount("fc_count", 1);
    checkWord("fc_w0", 64'h0064_0063_0062_0061, 8'hFF, 1'b1, 1'b1);
`endif

    // Frame D: enable drops after two samples, the rest is ignored until a new frame start
    applyStimulus(15'h71, 1'b0, 1'b1, 1'b0);
    applyStimulus(15'h72, 1'b0, 1'b0, 1'b0);
    enable = 1'b0;
    @(posedge clk); #1;
    enable = 1'b1;
    applyStimulus(15'h73, 1'b0, 1'b0, 1'b0);
    applyStimulus(15'h74, 1'b0, 1'b0, 1'b1);
`ifdef LVDS_PACK_HDR_EN
    expectCount("fd_count", 1);
    checkWord("fd_hdr", 64'hA110_0004_0000_0001, 8'hFF, 1'b0, 1'b1);
`else
    expectCount("fd_count", 0);
`endif

    // Overflow: stalled consumer, FIFO_DEPTH+3 full words offered
    m_tready = 1'b0;
    for (int w = 0; w < FIFO_DEPTH + 3; w++)
      for (int j = 0; j < 4; j++)
        applyStimulus(DW'(4*w + j + 1), 1'b0, (w == 0) && (j == 0), 1'b0);
    checkOutput("ovf_flag", 80'(overflow), 80'(1));
    checkOutput("ovf_drop_cnt", 80'(drop_cnt), 80'(1));
    checkOutput("ovf_tvalid", 80'(m_tvalid), 80'(1));
`ifdef LVDS_PACK_HDR_EN
    checkOutput("stall0_start", 80'(m_tdata), 80'(64'hA110_0005_0000_0000));
    repeat (5) begin @(posedge clk); #1; end
    checkOutput("stall0_end", 80'(m_tdata), 80'(64'hA110_0005_0000_0000));
`else
    checkOutput("stall0_start", 80'(m_tdata), 80'(64'h0004_0003_0002_0001));
    repeat (5) begin @(posedge clk); #1; end
    checkOutput("stall0_end", 80'(m_tdata), 80'(64'h0004_0003_0002_0001));
`endif
    m_tready = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    m_tready = 1'b0;
`ifdef LVDS_PACK_HDR_EN
    checkOutput("stall1_start", 80'(m_tdata), 80'(64'h000C_000B_000A_0009));
    repeat (4) begin @(posedge clk); #1; end
    checkOutput("stall1_end", 80'(m_tdata), 80'(64'h000C_000B_000A_0009));
`else
    checkOutput("stall1_start", 80'(m_tdata), 80'(64'h0010_000F_000E_000D));
    repeat (4) begin @(posedge clk); #1; end
    checkOutput("stall1_end", 80'(m_tdata), 80'(64'h0010_000F_000E_000D));
`endif
    m_tready = 1'b1;
    expectCount("ovf_drain_count", FIFO_DEPTH);
`ifdef LVDS_PACK_HDR_EN
    checkWord("ovf_hdr", 64'hA110_0005_0000_0000, 8'hFF, 1'b0, 1'b1);
    for (int w = 0; w < FIFO_DEPTH - 1; w++)
      checkWord($sformatf("ovf_w%0d", w),
                {16'(4*w + 4), 16'(4*w + 3), 16'(4*w + 2), 16'(4*w + 1)}, 8'hFF, 1'b0, 1'b0);
`else
    for (int w = 0; w < FIFO_DEPTH; w++)
      checkWord($sformatf("ovf_w%0d", w),
                {16'(4*w + 4), 16'(4*w + 3), 16'(4*w + 2), 16'(4*w + 1)}, 8'hFF, 1'b0, w == 0);
`endif
    sendLine(16'h200, 4, 1'b0, 1'b0);
    expectCount("post_ovf_count", 0);

    // Reset mid-frame with a word pending and overflow set
    m_tready = 1'b0;
    sendLine(16'h300, 4, 1'b0, 1'b1);
    applyStimulus(15'h310, 1'b0, 1'b1, 1'b0);
    applyStimulus(15'h311, 1'b0, 1'b0, 1'b0);
    checkOutput("pre_rst_tvalid", 80'(m_tvalid), 80'(1));
    rst = 1'b1;
    #2;
    checkOutput("mid_rst_tvalid", 80'(m_tvalid), 80'(0));
    checkOutput("mid_rst_tdata", 80'(m_tdata), 80'(0));
    checkOutput("mid_rst_overflow", 80'(overflow), 80'(0));
    checkOutput("mid_rst_drop_cnt", 80'(drop_cnt), 80'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    got.delete();
    m_tready = 1'b1;
    @(posedge clk); #1;

    sendLine(16'h401, 4, 1'b0, 1'b1);
`ifdef LVDS_PACK_HDR_EN
    expectCount("after_rst_count", 2);
    checkWord("after_rst_hdr", 64'hA110_0000_0000_0000, 8'hFF, 1'b0, 1'b1);
    checkWord("after_rst_w0", 64'h0404_0403_0402_0401, 8'hFF, 1'b1, 1'b0);
`else
    expectCount("after_rst_count", 1);
    checkWord("after_rst_w0", 64'h0404_0403_0402_0401, 8'hFF, 1'b1, 1'b1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
